// File: rtl/snake_pkg.sv
// snake_pkg: state, collision and direction codes shared by the snake game blocks.
package snake_pkg;
    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_PLAY      = 2'b01,
        ST_GAME_OVER = 2'b11
    } state_e;
    typedef enum logic [1:0] {
        COL_NONE  = 2'b00,
        COL_DEATH = 2'b01,
        COL_APPLE = 2'b10
    } coll_e;
    typedef enum logic [2:0] {
        DIR_IDLE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_e;
endpackage

// File: rtl/frame_tick_counter.sv
// frame_tick_counter: modulo-N counter of enabled frame_end pulses.
// Wrap is combinational on the enabled pulse that takes the count from N-1 back to 0.
module frame_tick_counter #(
    parameter int N = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic wrap
);
    localparam int W = N > 1 ? $clog2(N) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        wrap  = en && cnt_q == W'(N - 1);
        cnt_d = (clr || wrap) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
endmodule

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: IDLE/PLAY/GAME_OVER control, per-frame collision classification and move tick.
// Define SNAKE_SELF_COLLISION_EN to make head/body overlap end the game.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int BIT           = 10,
    parameter int UPDATE_FRAMES = 8,
    parameter int GO_FRAMES     = 60
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           frame_end,
    input  logic [BIT-1:0] x_pos,
    input  logic [BIT-1:0] y_pos,
    input  logic           snake_head_active,
    input  logic           snake_body_active,
    input  logic           apple_active,
    input  logic           start_btn,
    output logic [1:0]     game_state,
    output logic [1:0]     collision,
    output logic           update,
    output logic [7:0]     score
);
    state_e     state_q, state_d;
    logic [1:0] coll_q, coll_d, prev_coll_q;
    logic [7:0] score_q, score_d;
    logic       start_q, update_q, update_d;
    logic       seen_head_q, apple_hit_q;
    logic       head_now, apple_now, self_now;
    logic       in_play, death, start_edge, upd_wrap, go_wrap;
    logic       unused_pos;

    // Current pixel is folded in so a flag coincident with frame_end counts for the ending frame
    assign head_now   = seen_head_q | snake_head_active;
    assign apple_now  = apple_hit_q | (snake_head_active & apple_active);
    assign in_play    = state_q == ST_PLAY;
    assign death      = in_play & (self_now | !head_now);
    assign start_edge = start_btn & !start_q;

`ifdef SNAKE_SELF_COLLISION_EN
    logic self_hit_q;
    assign self_now   = self_hit_q | (snake_head_active & snake_body_active);
    assign unused_pos = ^{x_pos, y_pos};
    always_ff @(posedge clk or posedge reset)
        if (reset) self_hit_q <= 1'b0;
        else       self_hit_q <= !frame_end && self_now;
`else
    assign self_now   = 1'b0;
    assign unused_pos = ^{x_pos, y_pos, snake_body_active};
`endif

    frame_tick_counter #(.N(UPDATE_FRAMES)) u_upd_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (!in_play),
        .en   (frame_end && in_play),
        .wrap (upd_wrap)
    );

    frame_tick_counter #(.N(GO_FRAMES)) u_go_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (state_q != ST_GAME_OVER),
        .en   (frame_end && state_q == ST_GAME_OVER),
        .wrap (go_wrap)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start_edge) state_d = ST_PLAY;
            ST_PLAY:      if (frame_end && death) state_d = ST_GAME_OVER;
            ST_GAME_OVER: if (go_wrap) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        // A death result survives one cycle into GAME_OVER, then the non-PLAY force clears it
        coll_d   = !in_play ? COL_NONE : !frame_end ? coll_q :
                   death ? COL_DEATH : apple_now ? COL_APPLE : COL_NONE;
        update_d = upd_wrap && !death;
        score_d  = (state_q == ST_IDLE && start_edge) ? 8'd0 :
                   (coll_q == COL_APPLE && prev_coll_q != COL_APPLE && score_q != 8'hFF) ?
                   score_q + 8'd1 : score_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            coll_q      <= COL_NONE;
            prev_coll_q <= COL_NONE;
            score_q     <= 8'd0;
            start_q     <= 1'b0;
            update_q    <= 1'b0;
            seen_head_q <= 1'b0;
            apple_hit_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            coll_q      <= coll_d;
            prev_coll_q <= coll_q;
            score_q     <= score_d;
            start_q     <= start_btn;
            update_q    <= update_d;
            seen_head_q <= !frame_end && head_now;
            apple_hit_q <= !frame_end && apple_now;
        end
    end

    assign game_state = state_q;
    assign collision  = coll_q;
    assign update     = update_q;
    assign score      = score_q;
endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: table vectors, directed corner sequences and random frames
// checked against a frame-level game model.
module tb_snake_game_ctrl;
    localparam int UF = 8;
    localparam int GF = 60;

    logic       clk = 0, reset = 0, frame_end = 0, start_btn = 0;
    logic       head = 0, body = 0, apple = 0;
    logic [9:0] x_pos = 0, y_pos = 0;
    logic [1:0] game_state, collision;
    logic       update;
    logic [7:0] score;

    int n_chk = 0, n_pass = 0;
    int m_state, m_coll, m_score, m_prev, m_frames, m_go;
    int oc, os, ou, osc;

    typedef struct {
        logic [3:0] h, a, b;
        int coll, state, upd, score;
    } vec_t;
    vec_t tbl[10];

    always #5 clk = ~clk;

    snake_game_ctrl #(.BIT(10), .UPDATE_FRAMES(UF), .GO_FRAMES(GF)) dut (
        .clk              (clk),
        .reset            (reset),
        .frame_end        (frame_end),
        .x_pos            (x_pos),
        .y_pos            (y_pos),
        .snake_head_active(head),
        .snake_body_active(body),
        .apple_active     (apple),
        .start_btn        (start_btn),
        .game_state       (game_state),
        .collision        (collision),
        .update           (update),
        .score            (score)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc(input logic fe, input logic h, input logic a, input logic b, input logic s);
        frame_end = fe;
        head      = h;
        apple     = a;
        body      = b;
        start_btn = s;
        x_pos     = x_pos + 10'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_state = 0; m_coll = 0; m_score = 0; m_prev = 0; m_frames = 0; m_go = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        cyc(0, 0, 0, 0, 0);
        reset = 0;
        cyc(0, 0, 0, 0, 0);
        m_reset();
    endtask

    task automatic press();
        cyc(0, 0, 0, 0, 1);
        if (m_state == 0) begin
            m_state = 1; m_score = 0; m_coll = 0; m_prev = 0; m_frames = 0;
        end
        chk("press_state", game_state, m_state);
        chk("press_score", score, m_score);
        cyc(0, 0, 0, 0, 0);
    endtask

    // Four pixel cycles (frame_end on the last), then one empty cycle of the next frame
    task automatic frame(input logic [3:0] h, input logic [3:0] a, input logic [3:0] b, input bit st,
                         output int o_coll, output int o_state, output int o_upd, output int o_score);
        bit hd, ap, sf, death;
        int exp_upd;
        hd = |h;
        ap = |(h & a);
`ifdef SNAKE_SELF_COLLISION_EN
        sf = |(h & b);
`else
        sf = 0;
`endif
        for (int i = 0; i < 3; i++) begin
            cyc(0, h[i], a[i], b[i], 0);
            chk("mid_update", update, 0);
        end
        cyc(1, h[3], a[3], b[3], st);
        o_coll  = collision;
        o_state = game_state;
        o_upd   = update;
        exp_upd = 0;
        if (m_state == 1) begin
            death  = sf || !hd;
            m_coll = death ? 1 : ap ? 2 : 0;
            if (m_coll == 2 && m_prev != 2 && m_score < 255) m_score++;
            m_prev = m_coll;
            if (death) begin
                m_state = 3;
                m_go    = 0;
            end else begin
                m_frames++;
                exp_upd = (m_frames % UF == 0) ? 1 : 0;
            end
        end else begin
            m_coll = 0;
            m_prev = 0;
            if (m_state == 3) begin
                m_go++;
                if (m_go == GF) m_state = 0;
            end else if (st) begin
                m_state = 1; m_score = 0; m_frames = 0;
            end
        end
        chk("state_t1", game_state, m_state);
        chk("coll_t1", collision, m_coll);
        chk("update_t1", update, exp_upd);
        cyc(0, 0, 0, 0, 0);
        o_score = score;
        chk("score_t2", score, m_score);
        chk("update_t2", update, 0);
        chk("coll_t2", collision, m_state == 1 ? m_coll : 0);
    endtask

    initial begin
        tbl[0] = '{4'hF, 4'h0, 4'h0, 0, 1, 0, 0};
        tbl[1] = '{4'hF, 4'h4, 4'h0, 2, 1, 0, 1};
        tbl[2] = '{4'hF, 4'h4, 4'h0, 2, 1, 0, 1};
        tbl[3] = '{4'hF, 4'h4, 4'h0, 2, 1, 0, 1};
        tbl[4] = '{4'hF, 4'h0, 4'h0, 0, 1, 0, 1};
        tbl[5] = '{4'hF, 4'h0, 4'h0, 0, 1, 0, 1};
        tbl[6] = '{4'hF, 4'h0, 4'h0, 0, 1, 0, 1};
        tbl[7] = '{4'hF, 4'h0, 4'h0, 0, 1, 1, 1};
`ifdef SNAKE_SELF_COLLISION_EN
        tbl[8] = '{4'hF, 4'h4, 4'h4, 1, 3, 0, 1};
        tbl[9] = '{4'h0, 4'h0, 4'h0, 0, 3, 0, 1};
`else
        tbl[8] = '{4'hF, 4'h4, 4'h4, 2, 1, 0, 2};
        tbl[9] = '{4'h0, 4'h0, 4'h0, 1, 3, 0, 2};
`endif
        #1 reset = 1;
        #2;
        chk("rst_state", game_state, 0);
        chk("rst_coll", collision, 0);
        chk("rst_update", update, 0);
        chk("rst_score", score, 0);
        do_reset();

        press();
        for (int i = 0; i < 10; i++) begin
            frame(tbl[i].h, tbl[i].a, tbl[i].b, 0, oc, os, ou, osc);
            chk($sformatf("tbl%0d_coll", i), oc, tbl[i].coll);
            chk($sformatf("tbl%0d_state", i), os, tbl[i].state);
            chk($sformatf("tbl%0d_update", i), ou, tbl[i].upd);
            chk($sformatf("tbl%0d_score", i), osc, tbl[i].score);
        end

        // wall hit on the frame whose tick is due, then the full GAME_OVER dwell
        do_reset();
        press();
        for (int i = 0; i < 7; i++) frame(4'hF, 4'h0, 4'h0, 0, oc, os, ou, osc);
        frame(4'h0, 4'h0, 4'h0, 0, oc, os, ou, osc);
        chk("wall_coll", oc, 1);
        chk("wall_state", os, 3);
        chk("wall_update", ou, 0);
        press();
        chk("go_start_ignored", game_state, 3);
        chk("go_coll_none", collision, 0);
        for (int i = 1; i <= GF; i++) begin
            frame(4'hF, 4'h0, 4'h0, 0, oc, os, ou, osc);
            chk("go_state", os, i == GF ? 0 : 3);
            chk("go_update", ou, 0);
            chk("go_coll", oc, 0);
        end

        // async reset in the middle of a PLAY frame with score 5
        do_reset();
        press();
        for (int i = 0; i < 5; i++) begin
            frame(4'hF, 4'h2, 4'h0, 0, oc, os, ou, osc);
            frame(4'hF, 4'h0, 4'h0, 0, oc, os, ou, osc);
        end
        chk("score_five", score, 5);
        cyc(0, 1, 1, 1, 0);
        #2 reset = 1;
        #1;
        chk("mid_rst_state", game_state, 0);
        chk("mid_rst_coll", collision, 0);
        chk("mid_rst_update", update, 0);
        chk("mid_rst_score", score, 0);
        @(negedge clk) reset = 0;
        m_reset();
        frame(4'h0, 4'h0, 4'h0, 0, oc, os, ou, osc);
        chk("post_rst_coll", oc, 0);
        chk("post_rst_state", os, 0);

        // start edge coincident with frame_end while IDLE
        frame(4'hF, 4'h8, 4'h0, 1, oc, os, ou, osc);
        chk("start_fe_state", os, 1);
        chk("start_fe_coll", oc, 0);

        for (int i = 0; i < 300; i++) begin
            logic [3:0] h, a, b;
            h = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            a = 4'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if (m_state == 0 && $urandom_range(0, 3) == 0) press();
            frame(h, a, b, m_state == 0 && $urandom_range(0, 1) == 1, oc, os, ou, osc);
        end

        // score saturation
        do_reset();
        press();
        for (int i = 0; i < 260; i++) begin
            frame(4'hF, 4'h1, 4'h0, 0, oc, os, ou, osc);
            frame(4'hF, 4'h0, 4'h0, 0, oc, os, ou, osc);
        end
        chk("score_sat", score, 255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
